// File: rtl/uart_tx_controller.sv
// Sequencing FSM for the UART transmit datapath: accepts bytes, then drives shift/line/counter selects
// for one start bit, 8 data bits LSB-first and STOP_BITS stop bits. UART_TX_CTRL_QUEUE_EN adds a one-entry holding register.
module uart_tx_controller #(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic [7:0] tx_data_in,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic [7:0] tx_data_out,
   output logic [1:0] shift_tx_sel,
   output logic [1:0] tx_out_sel,
   output logic [1:0] UART_Baud_Counter_sel,
   output logic [1:0] bit_counter_sel,
   input  logic       baud_compare_val,
   input  logic       bit_counter_compare_val,
   output logic [1:0] dbg_state
);

   localparam logic [1:0] SH_HOLD    = 2'b01;
   localparam logic [1:0] SH_SHR     = 2'b10;
   localparam logic [1:0] SH_LOAD    = 2'b11;
   localparam logic [1:0] LINE_START = 2'b00;
   localparam logic [1:0] LINE_STOP  = 2'b10;
   localparam logic [1:0] LINE_DATA  = 2'b11;
   localparam logic [1:0] CNT_CLR    = 2'b00;
   localparam logic [1:0] CNT_HOLD   = 2'b01;
   localparam logic [1:0] CNT_INC    = 2'b10;
   localparam bit         TWO_STOP   = (STOP_BITS == 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   stop_flag_q, stop_flag_d;
   logic   done_q, done_d;
   logic   transfer;
   logic   last_stop_tick;
   logic   load_shift;
   logic   start_from_idle;
   logic   chain_frame;

   // Handshake: a byte is taken on any rising edge where tx_valid and tx_ready are both high;
   // tx_valid while tx_ready is low is simply ignored and never remembered.
   assign transfer       = tx_valid & tx_ready;
   assign last_stop_tick = (state_q == S_STOP) && baud_compare_val && !(TWO_STOP && !stop_flag_q);

`ifdef UART_TX_CTRL_QUEUE_EN
   logic       hold_full_q, hold_full_d;
   logic [7:0] hold_data_q, hold_data_d;

   assign tx_ready        = ~hold_full_q;
   assign tx_data_out     = hold_data_q;
   assign start_from_idle = hold_full_q;
   assign chain_frame     = hold_full_q;
   assign load_shift      = hold_full_q && ((state_q == S_IDLE) || last_stop_tick);

   // A write in the same cycle as a load-out wins, so the register stays full.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      if (load_shift) begin
         hold_full_d = 1'b0;
      end
      if (transfer) begin
         hold_full_d = 1'b1;
         hold_data_d = tx_data_in;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         hold_full_q <= 1'b0;
         hold_data_q <= 8'h00;
      end else begin
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
      end
   end
`else
   assign tx_ready        = (state_q == S_IDLE);
   assign tx_data_out     = tx_data_in;
   assign start_from_idle = transfer;
   assign chain_frame     = 1'b0;
   assign load_shift      = (state_q == S_IDLE) && transfer;
`endif

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= S_IDLE;
         stop_flag_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stop_flag_q <= stop_flag_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stop_flag_d = stop_flag_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_from_idle) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_compare_val) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_compare_val && bit_counter_compare_val) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_compare_val) begin
               if (TWO_STOP && !stop_flag_q) begin
                  stop_flag_d = 1'b1;
               end else begin
                  stop_flag_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = chain_frame ? S_START : S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bit counter reaches 1 on the start tick, so it reads 8 during the last data bit.
   always_comb begin
      shift_tx_sel          = SH_HOLD;
      tx_out_sel            = LINE_STOP;
      UART_Baud_Counter_sel = CNT_INC;
      bit_counter_sel       = CNT_HOLD;
      case (state_q)
         S_IDLE: begin
            tx_out_sel            = LINE_STOP;
            UART_Baud_Counter_sel = CNT_CLR;
            bit_counter_sel       = CNT_CLR;
         end
         S_START: begin
            tx_out_sel = LINE_START;
            if (baud_compare_val) begin
               UART_Baud_Counter_sel = CNT_CLR;
               bit_counter_sel       = CNT_INC;
            end
         end
         S_DATA: begin
            tx_out_sel = LINE_DATA;
            if (baud_compare_val) begin
               UART_Baud_Counter_sel = CNT_CLR;
               if (bit_counter_compare_val) begin
                  bit_counter_sel = CNT_CLR;
               end else begin
                  shift_tx_sel    = SH_SHR;
                  bit_counter_sel = CNT_INC;
               end
            end
         end
         S_STOP: begin
            tx_out_sel = LINE_STOP;
            if (baud_compare_val) begin
               UART_Baud_Counter_sel = CNT_CLR;
            end
         end
         default: tx_out_sel = LINE_STOP;
      endcase
      if (load_shift) begin
         shift_tx_sel = SH_LOAD;
      end
   end

   assign tx_busy   = (state_q != S_IDLE);
   assign tx_done   = done_q;
   assign dbg_state = state_q;

endmodule
